// File: rtl/ram_bist_pkg.sv
// Shared state encoding and default geometry/pattern for the RAM BIST master.
package ram_bist_pkg;
  localparam int         ADDR_W_DEF  = 4;
  localparam int         DATA_W_DEF  = 8;
  localparam int         RD_LAT_DEF  = 1;
  localparam logic [7:0] PATTERN_DEF = 8'hA5;

  typedef enum logic [2:0] {IDLE, WR0, RD0, WT0, WR1, RD1, WT1, FIN} state_t;
endpackage

// File: rtl/ram_bist_addr_cnt.sv
// Loadable up/down address counter; o_nxt is the stepped value, o_tc flags the
// terminal address for the current direction.
module ram_bist_addr_cnt import ram_bist_pkg::*; #(
  parameter int W = ADDR_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_up,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_nxt,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;

  assign o_nxt = i_up ? r_cnt + W'(1) : r_cnt - W'(1);
  assign o_tc  = i_up ? (&r_cnt) : ~(|r_cnt);
  assign o_cnt = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_en)   r_cnt <= o_nxt;
  end
endmodule

// File: rtl/ram_bist_master_8b.sv
// Two-pass (D0 ascending, D1 descending) write/verify BIST master; stops at the
// first mismatch and reports its address and read data.
module ram_bist_master_8b import ram_bist_pkg::*; #(
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter int                DATA_W  = DATA_W_DEF,
  parameter int                RD_LAT  = RD_LAT_DEF,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(PATTERN_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              mem_cs,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [ADDR_W-1:0] TOP_A = '1;

  state_t            r_state;
  logic              r_busy, r_done, r_pass, r_fail, r_cs, r_wr, r_rd;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_data, r_wdata;
  logic [2:0]        r_wt;

  logic [ADDR_W-1:0] w_cnt, w_nxt, w_ld_val;
  logic              w_tc, w_ld, w_en, w_up, w_cmp, w_miss;
  logic [DATA_W-1:0] w_exp, w_nd0;

  // Counter holds the address of the access in flight, including its wait cycles.
  ram_bist_addr_cnt #(.W(ADDR_W)) u_cnt (
    .clk(clk), .rst(rst), .i_load(w_ld), .i_load_val(w_ld_val), .i_en(w_en),
    .i_up(w_up), .o_cnt(w_cnt), .o_nxt(w_nxt), .o_tc(w_tc)
  );

  assign w_up   = (r_state == WR0) || (r_state == RD0) || (r_state == WT0);
  assign w_exp  = w_up ? (PATTERN ^ DATA_W'(w_cnt)) : ~(PATTERN ^ DATA_W'(w_cnt));
  assign w_nd0  = PATTERN ^ DATA_W'(w_nxt);
  assign w_cmp  = ((r_state == WT0) || (r_state == WT1)) && (r_wt == 3'd0);
  assign w_miss = w_cmp && (mem_rdata != w_exp);

  always_comb begin
    w_ld     = 1'b0;
    w_ld_val = '0;
    w_en     = 1'b0;
    case (r_state)
      IDLE: w_ld = start;
      WR0:  begin w_ld = w_tc; w_en = !w_tc; end
      WT0:  if (w_cmp && !w_miss) begin
              w_ld = w_tc; w_ld_val = TOP_A; w_en = !w_tc;
            end
      WR1:  begin w_ld = w_tc; w_ld_val = TOP_A; w_en = !w_tc; end
      WT1:  w_en = w_cmp && !w_miss && !w_tc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy <= 1'b0; r_done <= 1'b0; r_pass <= 1'b0; r_fail <= 1'b0;
      r_fail_addr <= '0; r_fail_data <= '0;
      r_cs <= 1'b0; r_wr <= 1'b0; r_rd <= 1'b0; r_wdata <= '0; r_wt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= WR0; r_busy <= 1'b1;
          r_pass <= 1'b0; r_fail <= 1'b0; r_fail_addr <= '0; r_fail_data <= '0;
          r_wr <= 1'b1; r_cs <= 1'b1; r_wdata <= PATTERN;
        end
        WR0: if (w_tc) begin
          r_state <= RD0; r_wr <= 1'b0; r_rd <= 1'b1;
        end else r_wdata <= w_nd0;
        WR1: if (w_tc) begin
          r_state <= RD1; r_wr <= 1'b0; r_rd <= 1'b1;
        end else r_wdata <= ~w_nd0;
        RD0, RD1: begin
          r_state <= (r_state == RD0) ? WT0 : WT1;
          r_rd <= 1'b0; r_cs <= 1'b0; r_wt <= 3'(RD_LAT - 1);
        end
        WT0, WT1: begin
          if (!w_cmp) r_wt <= r_wt - 3'd1;
          else if (w_miss) begin
            r_state <= FIN; r_fail <= 1'b1; r_fail_addr <= w_cnt;
            r_fail_data <= mem_rdata; r_done <= 1'b1; r_busy <= 1'b0;
          end else if (w_tc) begin
            if (r_state == WT0) begin
              r_state <= WR1; r_wr <= 1'b1; r_cs <= 1'b1;
              r_wdata <= ~(PATTERN ^ DATA_W'(TOP_A));
            end else begin
              r_state <= FIN; r_pass <= 1'b1; r_done <= 1'b1; r_busy <= 1'b0;
            end
          end else begin
            r_state <= (r_state == WT0) ? RD0 : RD1; r_rd <= 1'b1; r_cs <= 1'b1;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;
  assign mem_cs    = r_cs;
  assign mem_write = r_wr;
  assign mem_read  = r_rd;
  assign mem_addr  = w_cnt;
  assign mem_wdata = r_wdata;
endmodule

// File: tb/tb_ram_bist_master_8b.sv
// Scoreboard bench: two BIST masters (read latency 1 and 2) on 16x8 RAM models
// with stuck-at fault injection; access trace and final result are checked.
module tb_ram_bist_master_8b;
  localparam logic [7:0] PAT = 8'hA5;

  typedef struct packed { logic d; logic wr; logic [3:0] a; logic [7:0] dat; } acc_t;
  typedef struct packed { logic d; logic [7:0] cyc; logic pass; logic fail;
                          logic [3:0] fa; logic [7:0] fd; } res_t;

  logic       clk = 1'b0, rst = 1'b1;
  logic       start [2], busy [2], done [2], pass [2], fail [2];
  logic       cs [2], wr [2], rd [2], fen [2];
  logic [3:0] fail_addr [2], addr [2], fa_cfg [2];
  logic [7:0] fail_data [2], wdata [2], rdata [2], sa0 [2], sa1 [2];

  acc_t exp_acc [$];
  res_t exp_res [$];
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] mem  [16];
    logic [7:0] pipe [2];

    ram_bist_master_8b #(.ADDR_W(4), .DATA_W(8), .RD_LAT(g + 1), .PATTERN(PAT)) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .pass(pass[g]), .fail(fail[g]), .fail_addr(fail_addr[g]), .fail_data(fail_data[g]),
      .mem_cs(cs[g]), .mem_write(wr[g]), .mem_read(rd[g]), .mem_addr(addr[g]),
      .mem_wdata(wdata[g]), .mem_rdata(rdata[g])
    );

    always @(posedge clk) begin
      if (wr[g]) mem[addr[g]] <= wdata[g];
      if (rd[g]) pipe[0] <= (fen[g] && addr[g] == fa_cfg[g]) ?
                            ((mem[addr[g]] & ~sa0[g]) | sa1[g]) : mem[addr[g]];
      pipe[1] <= pipe[0];
    end
    assign rdata[g] = pipe[g];
  end

  // Monitor: pops the expected access on every strobe cycle and the expected
  // result on every done pulse; cycles are counted from the busy rising edge.
  logic pbusy [2];
  int   cyc [2];
  initial begin
    pbusy = '{1'b0, 1'b0};
    cyc   = '{0, 0};
    forever begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        acc_t ga, ea;
        res_t gr, er;
        if (busy[d] && !pbusy[d]) cyc[d] = 0; else cyc[d]++;
        pbusy[d] = busy[d];
        if (!rst && (cs[d] || rd[d] || wr[d])) begin
          checks++;
          ga.d = 1'(d); ga.wr = wr[d]; ga.a = addr[d]; ga.dat = wr[d] ? wdata[d] : 8'h00;
          if (cs[d] !== (rd[d] | wr[d]) || (rd[d] && wr[d])) begin
            errors++;
            $display("FAIL strobes dut%0d cs=%b rd=%b wr=%b (need cs=rd|wr, not rd&wr)",
                     d, cs[d], rd[d], wr[d]);
          end else if (exp_acc.size() == 0) begin
            errors++;
            $display("FAIL unexpected access dut%0d got %h, none expected", d, ga);
          end else begin
            ea = exp_acc.pop_front();
            if (ga !== ea) begin
              errors++;
              $display("FAIL access dut%0d got d/wr/a/dat=%h required %h", d, ga, ea);
            end
          end
        end
        if (!rst && done[d]) begin
          checks++;
          gr = '{1'(d), 8'(cyc[d]), pass[d], fail[d], fail_addr[d], fail_data[d]};
          if (exp_res.size() == 0) begin
            errors++;
            $display("FAIL unexpected done dut%0d", d);
          end else begin
            er = exp_res.pop_front();
            if (gr !== er) begin
              errors++;
              $display("FAIL result dut%0d got cyc=%0d pass=%b fail=%b fa=%h fd=%h required cyc=%0d pass=%b fail=%b fa=%h fd=%h",
                       d, gr.cyc, gr.pass, gr.fail, gr.fa, gr.fd, er.cyc, er.pass, er.fail, er.fa, er.fd);
            end
          end
        end
      end
    end
  end

  // Expected access trace of one run, truncated after the read at (stop_ph, stop_a).
  task automatic exp_run(input int d, input int stop_ph, input int stop_a, input int ncyc,
                         input logic ep, input logic ef, input logic [3:0] efa,
                         input logic [7:0] efd, input logic with_res);
    bit   stop = 0;
    int   a;
    acc_t e;
    for (int ph = 0; ph < 4 && !stop; ph++)
      for (int i = 0; i < 16 && !stop; i++) begin
        a     = (ph < 2) ? i : 15 - i;
        e.d   = 1'(d);
        e.wr  = (ph == 0 || ph == 2);
        e.a   = 4'(a);
        e.dat = !e.wr ? 8'h00 : (ph == 0) ? (PAT ^ 8'(a)) : ~(PAT ^ 8'(a));
        exp_acc.push_back(e);
        if (ph == stop_ph && a == stop_a) stop = 1;
      end
    if (with_res) exp_res.push_back('{1'(d), 8'(ncyc), ep, ef, efa, efd});
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, got, req);
    end
  endtask

  function automatic logic [63:0] outs(input int d);
    return 64'({busy[d], done[d], pass[d], fail[d], cs[d], wr[d], rd[d],
                fail_addr[d], fail_data[d], addr[d], wdata[d]});
  endfunction

  task automatic go(input int d);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    int n = 0;
    while (!done[d] && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (!done[d]) begin
      checks++; errors++;
      $display("FAIL timeout dut%0d no done within %0d cycles", d, budget);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    start = '{1'b0, 1'b0}; fen = '{1'b0, 1'b0};
    fa_cfg = '{4'h0, 4'h0}; sa0 = '{8'h00, 8'h00}; sa1 = '{8'h00, 8'h00};
    #12;
    chk("reset outs dut0", outs(0), 64'h0);
    chk("reset outs dut1", outs(1), 64'h0);
    @(posedge clk); #3 rst = 1'b0;
    idle(1);

    // Fault-free, latency 1
    exp_run(0, -1, -1, 96, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1);
    go(0); wait_done(0, 200); idle(3);

    // Address 3 bit 1 stuck-at-0: D0(3)=A6 reads back A4
    fen[0] = 1'b1; fa_cfg[0] = 4'h3; sa0[0] = 8'h02; sa1[0] = 8'h00;
    exp_run(0, 1, 3, 24, 1'b0, 1'b1, 4'h3, 8'hA4, 1'b1);
    go(0); wait_done(0, 200); idle(3);
    chk("fail held dut0", 64'(fail[0]), 64'h1);
    chk("pass low dut0", 64'(pass[0]), 64'h0);
    fen[0] = 1'b0;

    // Fault-free, latency 2
    exp_run(1, -1, -1, 128, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1);
    go(1); wait_done(1, 300); idle(3);

    // Start pulsed at cycle 20 of a run is ignored
    exp_run(0, -1, -1, 96, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1);
    go(0);
    repeat (19) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    chk("busy during pulse", 64'(busy[0]), 64'h1);
    wait_done(0, 200); idle(3);

    // Reset during WR1, then a clean run
    exp_run(0, -1, -1, 96, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0);
    go(0);
    repeat (54) @(posedge clk);
    #3;
    chk("in WR1 write", 64'({wr[0], addr[0]}), 64'h19);
    rst = 1'b1;
    #1;
    chk("mid-test reset outs", outs(0), 64'h0);
    exp_acc.delete();
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    idle(1);
    exp_run(0, -1, -1, 96, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1);
    go(0); wait_done(0, 200); idle(3);

    // Back-to-back with start held; second run has addr F bit 1 stuck-at-1
    exp_run(0, -1, -1, 96, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1);
    exp_run(0, 3, 15, 66, 1'b0, 1'b1, 4'hF, 8'h57, 1'b1);
    start[0] = 1'b1;
    wait_done(0, 200);
    fen[0] = 1'b1; fa_cfg[0] = 4'hF; sa0[0] = 8'h00; sa1[0] = 8'h02;
    @(posedge clk); #2;
    chk("pass held in idle", 64'({busy[0], pass[0]}), 64'h1);
    @(posedge clk); #2;
    chk("pass cleared on start", 64'({busy[0], pass[0], fail[0]}), 64'h4);
    start[0] = 1'b0;
    wait_done(0, 200); idle(4);
    fen[0] = 1'b0;

    chk("access queue drained", 64'(exp_acc.size()), 64'h0);
    chk("result queue drained", 64'(exp_res.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_bist_master_8b.md
RAM_BIST_MASTER_8B -- requirements
Module: ram_bist_master_8b

Interface
REQ-001 SHALL provide parameters:
- ADDR_W, default 4: memory address width.
- DATA_W, default 8: memory data width.
- RD_LAT, default 1: cycles from the edge sampling mem_read to valid mem_rdata; legal values 1..4.
- PATTERN, default 8'hA5: base test pattern.

REQ-002 SHALL have exactly these ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  test request, sampled only in IDLE.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  test passed, held until next accepted start.
- fail  out  1  mismatch found, held until next accepted start.
- fail_addr  out  ADDR_W  address of first mismatch.
- fail_data  out  DATA_W  data read at first mismatch.
- mem_cs  out  1  chip select, high only in access cycles.
- mem_write  out  1  write strobe.
- mem_read  out  1  read strobe.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data from the RAM controller.

Function
REQ-003 SHALL implement FSM states IDLE, WR0, RD0, WT0, WR1, RD1, WT1, FIN.
REQ-004 SHALL, in IDLE with start=1 at edge N, clear pass/fail/fail_addr/fail_data, set busy, and drive the first write in cycle N+1.
REQ-005 SHALL define expected data D0(a) = PATTERN ^ zero-extended a, and D1(a) = ~D0(a).
REQ-006 SHALL run the phases in this order:
- WR0: write D0 ascending 0..2^ADDR_W-1, one write per cycle.
- RD0/WT0: verify D0 ascending.
- WR1: write D1 descending.
- RD1/WT1: verify D1 descending.
REQ-007 SHALL, per read, assert mem_read and mem_cs for exactly one cycle (RDx), wait RD_LAT cycles (WTx), then compare mem_rdata to expected data in the final WTx cycle.
REQ-008 SHALL never assert mem_read and mem_write in the same cycle; mem_cs SHALL equal mem_read | mem_write.
REQ-009 SHALL hold mem_addr and mem_wdata stable throughout each access cycle; both are don't-care outside access cycles.
REQ-010 SHALL, on the first mismatch, capture fail_addr and fail_data, set fail, and go to FIN without issuing further accesses.
REQ-011 SHALL, in FIN, pulse done for one cycle, set pass=~fail, clear busy, and return to IDLE.
REQ-012 SHALL, on a passing run with ADDR_W=4, take 2*16 + 2*16*(1+RD_LAT) cycles from start acceptance to the done pulse: 96 cycles at RD_LAT=1, 128 at RD_LAT=2.
REQ-013 SHALL ignore start while busy; start held high after done SHALL begin a new test in the cycle following the return to IDLE.
REQ-014 SHALL wrap the address counter only at phase boundaries; the terminal address ends the phase, and the counter never wraps within a phase.

Reset
REQ-015 SHALL, on rst=1, asynchronously force state IDLE and all outputs to 0 (busy, done, pass, fail, fail_addr, fail_data, mem_cs, mem_write, mem_read, mem_addr, mem_wdata).
REQ-016 SHALL, on reset asserted mid-test, drop all memory strobes immediately; no partial result is retained.

Structure
REQ-017 SHALL place the state enumeration and the default ADDR_W/DATA_W/RD_LAT/PATTERN values in shared package ram_bist_pkg.
REQ-018 SHALL use one sub-module, ram_bist_addr_cnt: a loadable up/down ADDR_W counter with a terminal-count flag.

Verification
REQ-019 Bench SHALL use a 16x8 RAM model with configurable read latency and fault injection, and SHALL cover these scenarios:
- Fault-free, RD_LAT=1 -> done at cycle 96, pass=1, fail=0, 16 writes then 16 reads per phase, no read/write overlap.
- Bit 1 of address 4'h3 stuck-at-0 -> RD0 reads 8'hA4 (expected 8'hA6), fail=1, fail_addr=4'h3, fail_data=8'hA4, no accesses after the mismatch.
- RD_LAT=2, fault-free -> done at cycle 128, pass=1.
- start pulsed at cycle 20 of a run -> ignored, total cycles and result unchanged.
- rst asserted during WR1 -> all outputs 0 within the same cycle; a following start completes with pass=1.
- Two back-to-back passing runs, second with a fault at address 4'hF -> pass/fail cleared on the second start; D1(4'hF)=8'h55 expected, fail_addr=4'hF.
